conv_out_writer: RTL and testbench

- Downstream stage of the 3x3 convolution datapath. Consumes one 9-bit signed window sum per pixel push.
- Discards sums from windows that are not fully inside the image (pipeline warm-up and row wrap-around), clamps valid sums to 8-bit unsigned and writes them to the output frame memory at compact addresses.
- Tracks frame progress with a small FSM, signals frame completion and counts clipped results.

---
 rtl/conv_out_writer.sv | 144 ++++++++++++++
 tb/tb_conv_out_writer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_out_writer.sv
// conv_out_writer: final stage of the 3x3 convolution datapath.
// Drops window sums whose 3x3 window is not fully inside the image, clamps the
// remaining sums to 8-bit unsigned, and writes them to consecutive output
// addresses one cycle after the push. A three-state FSM tracks frame progress.
module conv_out_writer #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int SUM_W  = 9,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [SUM_W-1:0]  in_sum,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] clip_cnt
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic signed [SUM_W:0] PIX_MAX = (SUM_W+1)'(255);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [ADDR_W-1:0]   out_ptr_q, out_ptr_d;
  logic [ADDR_W-1:0]   clip_cnt_q, clip_cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;

  // Position and clamp decode for the current push.
  logic                col_last, row_last, win_valid;
  logic signed [SUM_W:0] sum_ext;
  logic                clamp_lo, clamp_hi;
  logic [7:0]          clamp_val;

  // Decode window position and the saturated pixel value of the incoming sum.
  always_comb begin
    col_last  = (col_q == COL_W'(IMG_W - 1));
    row_last  = (row_q == ROW_W'(IMG_H - 1));
    win_valid = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
    // One extra sign bit keeps the 255 threshold representable for any SUM_W.
    sum_ext   = $signed({in_sum[SUM_W-1], in_sum});
    clamp_lo  = in_sum[SUM_W-1];
    clamp_hi  = sum_ext > PIX_MAX;
    if (clamp_lo)      clamp_val = 8'd0;
    else if (clamp_hi) clamp_val = 8'd255;
    else               clamp_val = in_sum[7:0];
  end

  // Next-state logic: start (re)arms a frame from any state; pushes only count in RUN.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    out_ptr_d  = out_ptr_q;
    clip_cnt_d = clip_cnt_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (start) begin
      // A same-cycle push is discarded: the new frame starts from pixel 0.
      state_d    = S_RUN;
      col_d      = '0;
      row_d      = '0;
      out_ptr_d  = '0;
      clip_cnt_d = '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (in_valid) begin
            if (win_valid) begin
              wr_en_d   = 1'b1;
              wr_addr_d = out_ptr_q;
              wr_data_d = clamp_val;
              out_ptr_d = out_ptr_q + ADDR_W'(1);
              if (clamp_lo || clamp_hi) clip_cnt_d = clip_cnt_q + ADDR_W'(1);
            end
            if (col_last && row_last) begin
              state_d = S_DONE;
              col_d   = '0;
              row_d   = '0;
            end else if (col_last) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
        S_IDLE, S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers; reset clears everything, dropping any pending write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      out_ptr_q  <= '0;
      clip_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      out_ptr_q  <= out_ptr_d;
      clip_cnt_q <= clip_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign clip_cnt = clip_cnt_q;
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_out_writer.sv
// Self-checking bench for conv_out_writer on a 5x5 image. Expected writes are
// queued at push time and popped when wr_en is observed on the falling edge.
module tb_conv_out_writer;

  localparam int IMG_W  = 5;
  localparam int IMG_H  = 5;
  localparam int SUM_W  = 10;
  localparam int ADDR_W = 11;
  localparam int N_WR   = (IMG_W - 2) * (IMG_H - 2);

  logic              clk;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [SUM_W-1:0]  in_sum;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] clip_cnt;

  conv_out_writer #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .SUM_W (SUM_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .in_valid(in_valid),
    .in_sum  (in_sum),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .clip_cnt(clip_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    int                cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   wr_seen = 0;

  // Reference position tracker for the frame being pushed.
  int m_row, m_col, m_ptr;

  function automatic logic [7:0] clamp_ref(input int s);
    if (s < 0)        return 8'd0;
    else if (s > 255) return 8'd255;
    else              return 8'(s);
  endfunction

  function automatic int sum_for(input int k, input int mode);
    if (mode == 1) begin
      if (k == 0 || k == 12) return -5;
      if (k == 18)           return 300;
    end
    return k;
  endfunction

  task automatic model_clear();
    m_row = 0;
    m_col = 0;
    m_ptr = 0;
  endtask

  // One clock: rising edge, then observe writes on the falling edge.
  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (wr_en === 1'b1) begin
      wr_seen++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write cyc=%0d addr=%0d data=%0d", cyc, wr_addr, wr_data);
      end else begin
        e = sb_q.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL write cyc=%0d addr=%0d data=%0d : want cyc=%0d addr=%0d data=%0d",
                   cyc, wr_addr, wr_data, e.cyc, e.addr, e.data);
        end
      end
    end
  endtask

  task automatic push_px(input int s);
    exp_t e;
    in_valid = 1'b1;
    in_sum   = SUM_W'(s);
    if (m_row >= 2 && m_col >= 2) begin
      e.addr = ADDR_W'(m_ptr);
      e.data = clamp_ref(s);
      e.cyc  = cyc + 1;
      sb_q.push_back(e);
      m_ptr++;
    end
    if (m_col == IMG_W - 1) begin
      m_col = 0;
      m_row++;
    end else begin
      m_col++;
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic start_frame(input logic with_valid);
    start    = 1'b1;
    in_valid = with_valid;
    in_sum   = SUM_W'(99);
    step();
    start    = 1'b0;
    in_valid = 1'b0;
    model_clear();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || clip_cnt !== '0) begin
      errors++;
      $display("FAIL start busy=%b done=%b clip=%0d : want 1 0 0", busy, done, clip_cnt);
    end
  endtask

  // Pushes a full frame, optionally with random gaps, and checks the end state.
  task automatic run_frame(input string name, input int mode, input int gaps, input int exp_clip);
    wr_seen = 0;
    for (int k = 0; k < IMG_W * IMG_H; k++) begin
      push_px(sum_for(k, mode));
      if (k < IMG_W * IMG_H - 1) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s_busy k=%0d busy=%b done=%b : want 1 0", name, k, busy, done);
        end
        if (gaps != 0) begin
          int n;
          n = $urandom_range(0, 3);
          for (int g = 0; g < n; g++) step();
        end
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done done=%b busy=%b : want 1 0", name, done, busy);
    end
    step();
    checks++;
    if (clip_cnt !== ADDR_W'(exp_clip)) begin
      errors++;
      $display("FAIL %s_clip got %0d want %0d", name, clip_cnt, exp_clip);
    end
    checks++;
    if (wr_seen != N_WR || sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_count writes=%0d pending=%0d : want %0d 0", name, wr_seen, sb_q.size(), N_WR);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 ||
        busy !== 1'b0 || done !== 1'b0 || clip_cnt !== '0) begin
      errors++;
      $display("FAIL %s wr_en=%b addr=%0d data=%0d busy=%b done=%b clip=%0d : want all 0",
               name, wr_en, wr_addr, wr_data, busy, done, clip_cnt);
    end
  endtask

  task automatic idle_pulses(input string name, input int n);
    logic             done_before;
    logic [ADDR_W-1:0] clip_before;
    done_before = done;
    clip_before = clip_cnt;
    wr_seen = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_sum   = SUM_W'(-7 + i);
      step();
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (wr_seen != 0 || done !== done_before || clip_cnt !== clip_before || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s writes=%0d done=%b clip=%0d busy=%b : want 0 %b %0d 0",
               name, wr_seen, done, clip_cnt, busy, done_before, clip_before);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_sum   = '0;
    model_clear();
    #12;
    check_outputs_zero("reset_state");
    @(negedge clk);
    reset = 1'b1;
    step();
    check_outputs_zero("after_release");
  endtask

  task automatic test_idle_ignore();
    idle_pulses("idle_ignore", 4);
  endtask

  task automatic test_basic();
    start_frame(1'b0);
    run_frame("basic", 0, 0, 0);
  endtask

  task automatic test_clip();
    start_frame(1'b0);
    run_frame("clip", 1, 0, 2);
  endtask

  task automatic test_gaps();
    start_frame(1'b0);
    run_frame("gaps", 0, 1, 0);
  endtask

  task automatic test_done_ignore();
    idle_pulses("done_ignore", 3);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_hold done=%b want 1", done);
    end
    start_frame(1'b0);
    run_frame("after_done", 0, 0, 0);
  endtask

  task automatic test_abort();
    start_frame(1'b0);
    for (int k = 0; k < 14; k++) push_px(sum_for(k, 1));
    step();
    checks++;
    if (clip_cnt !== ADDR_W'(1)) begin
      errors++;
      $display("FAIL abort_pre_clip got %0d want 1", clip_cnt);
    end
    start_frame(1'b1);
    run_frame("abort", 0, 0, 0);
  endtask

  task automatic test_async_reset();
    start_frame(1'b0);
    for (int k = 0; k < 12; k++) push_px(k);
    in_valid = 1'b1;
    in_sum   = SUM_W'(12);
    @(posedge clk);
    cyc++;
    #2;
    checks++;
    if (wr_en !== 1'b1) begin
      errors++;
      $display("FAIL async_pre_wr got %b want 1", wr_en);
    end
    reset = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    in_valid = 1'b0;
    sb_q.delete();
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    idle_pulses("post_reset_idle", 3);
    start_frame(1'b0);
    run_frame("post_reset", 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_basic();
    test_clip();
    test_gaps();
    test_done_ignore();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
